mips32_dmem_arbiter: RTL and testbench

Two-port arbiter that shares the MIPS32 single-port data memory between the CPU load/store path and a debug/loader port. The debug/loader port replaces out-of-band memory preloading and dumping by testbenches. The block sits between the CPU memory stage, the debug port and the data memory array. It grants at most one access per cycle, returns read data with the memory's one-cycle latency and stalls the CPU while it waits. Debug bursts may lock the memory, and a wait counter bounds CPU starvation.

---
 rtl/mips32_dmem_arbiter.sv | 74 +++++++
 tb/tb_mips32_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_dmem_arbiter.sv
// mips32_dmem_arbiter: CPU/debug data-memory arbiter with debug lock and CPU starvation guard; `define DMEM_ARB_RR_EN for round-robin on contention
module mips32_dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef enum logic {NONE, DBG} owner_t;
  typedef enum logic {WIN_CPU, WIN_DBG} win_t;
  owner_t owner, owner_nx;
  win_t last, last_nx;
  logic [WW-1:0] cpu_wait, wait_nx;
  logic force_cpu, cpu_first;
  assign cpu_rdata = mem_rdata;
  assign dbg_rdata = mem_rdata;
  always_comb begin
    force_cpu = cpu_req && cpu_wait == WW'(MAX_WAIT);
    cpu_first = RR && last == WIN_DBG;
    cpu_gnt = !reset && cpu_req && (force_cpu || (owner == NONE && (!dbg_req || cpu_first)));
    dbg_gnt = !reset && dbg_req && !cpu_gnt;
    cpu_stall = cpu_req && !cpu_gnt;
    mem_en = cpu_gnt || dbg_gnt;
    mem_we = cpu_gnt ? cpu_we : dbg_gnt && dbg_we;
    mem_addr = cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : '0;
    owner_nx = !dbg_lock ? NONE : dbg_gnt ? DBG : owner;
    last_nx = cpu_gnt ? WIN_CPU : dbg_gnt ? WIN_DBG : last;
    wait_nx = (cpu_gnt || !cpu_req) ? '0 : cpu_wait == WW'(MAX_WAIT) ? cpu_wait : cpu_wait + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= NONE;
      last <= WIN_DBG;
      cpu_wait <= '0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      owner <= owner_nx;
      last <= last_nx;
      cpu_wait <= wait_nx;
      cpu_rvalid <= cpu_gnt && !cpu_we;
      dbg_rvalid <= dbg_gnt && !dbg_we;
    end
  end
endmodule

// File: tb/tb_mips32_dmem_arbiter.sv
// tb_mips32_dmem_arbiter: scoreboard bench for mips32_dmem_arbiter with MAX_WAIT=3
module tb_mips32_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MW = 3;
  typedef struct {int due; bit who; logic [DW-1:0] data;} exp_t;
  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  exp_t exp_q[$];
  int cyc = 0;
  int total = 0;
  int passed = 0;
  mips32_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [DW-1:0] seed(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= seed(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end
  task automatic cyc_next;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
  endtask
  task automatic test_reset;
    cpu_req = 1; dbg_req = 1; dbg_we = 1; dbg_addr = 8'h01; dbg_wdata = 32'h1;
    cyc_next;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b0) $display("FAIL reset_cpu_gnt: got %b want 0", cpu_gnt); else passed++;
    total++; if (dbg_gnt !== 1'b0) $display("FAIL reset_dbg_gnt: got %b want 0", dbg_gnt); else passed++;
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_mem_en_we: got %b%b want 00", mem_en, mem_we); else passed++;
    total++; if (cpu_stall !== 1'b1) $display("FAIL reset_stall: got %b want 1", cpu_stall); else passed++;
    total++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b%b want 00", cpu_rvalid, dbg_rvalid); else passed++;
    cyc_next;
    reset = 0; idle;
  endtask
  task automatic test_cpu_read;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h04;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0) $display("FAIL cpu_rd_gnt: got gnt=%b en=%b we=%b want 1 1 0", cpu_gnt, mem_en, mem_we); else passed++;
    total++; if (mem_addr !== 8'h04) $display("FAIL cpu_rd_addr: got %h want 04", mem_addr); else passed++;
    exp_q.push_back('{cyc + 1, 1'b0, ref_mem[4]});
    cyc_next; idle; cyc_next;
  endtask
  task automatic test_dbg_write_cpu_read;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h10; dbg_wdata = 32'h12345678;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b1) $display("FAIL dbg_wr_gnt: got gnt=%b we=%b want 1 1", dbg_gnt, mem_we); else passed++;
    total++; if (mem_addr !== 8'h10 || mem_wdata !== 32'h12345678) $display("FAIL dbg_wr_bus: got %h/%h want 10/12345678", mem_addr, mem_wdata); else passed++;
    ref_mem[8'h10] = 32'h12345678;
    cyc_next; idle;
    cpu_req = 1; cpu_addr = 8'h10;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1) $display("FAIL cpu_rd10_gnt: got %b want 1", cpu_gnt); else passed++;
    exp_q.push_back('{cyc + 1, 1'b0, ref_mem[8'h10]});
    cyc_next; idle; cyc_next;
  endtask
`ifndef DMEM_ARB_RR_EN
  task automatic test_priority;
    cpu_req = 1; cpu_addr = 8'h20; dbg_req = 1; dbg_addr = 8'h30;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) $display("FAIL prio_both: got cpu=%b dbg=%b want 0 1", cpu_gnt, dbg_gnt); else passed++;
    total++; if (cpu_stall !== 1'b1 || mem_addr !== 8'h30) $display("FAIL prio_stall: got stall=%b addr=%h want 1 30", cpu_stall, mem_addr); else passed++;
    exp_q.push_back('{cyc + 1, 1'b1, ref_mem[8'h30]});
    cyc_next;
    dbg_req = 0;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || mem_addr !== 8'h20) $display("FAIL prio_cpu_after: got gnt=%b stall=%b addr=%h want 1 0 20", cpu_gnt, cpu_stall, mem_addr); else passed++;
    exp_q.push_back('{cyc + 1, 1'b0, ref_mem[8'h20]});
    cyc_next; idle; cyc_next;
  endtask
`else
  task automatic test_round_robin;
    reset = 1;
    cyc_next;
    reset = 0;
    cpu_req = 1; cpu_addr = 8'h20; dbg_req = 1; dbg_addr = 8'h30;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (cpu_gnt !== (i % 2 == 0) || dbg_gnt !== (i % 2 == 1)) $display("FAIL rr_seq[%0d]: got cpu=%b dbg=%b want %b %b", i, cpu_gnt, dbg_gnt, i % 2 == 0, i % 2 == 1); else passed++;
      exp_q.push_back('{cyc + 1, i % 2 == 1, ref_mem[(i % 2 == 0) ? 8'h20 : 8'h30]});
      cyc_next;
    end
    idle; cyc_next;
  endtask
`endif
  task automatic test_starvation;
    int k = 0;
    int n = 0;
    bit want_c;
    for (int c = 0; c < 9; c++) begin
      want_c = (c == 4 || c == 8);
      dbg_req = 1; dbg_we = 1; dbg_lock = 1;
      dbg_addr = 8'(8'h40 + k); dbg_wdata = 32'hB0000000 + 32'(k);
      cpu_req = (c >= 1); cpu_we = 0; cpu_addr = 8'(8'h50 + n);
      @(negedge clk);
      total++; if (cpu_gnt !== want_c || dbg_gnt !== !want_c) $display("FAIL starve[%0d]: got cpu=%b dbg=%b want %b %b", c, cpu_gnt, dbg_gnt, want_c, !want_c); else passed++;
      total++; if (cpu_stall !== (c >= 1 && !want_c)) $display("FAIL starve_stall[%0d]: got %b want %b", c, cpu_stall, c >= 1 && !want_c); else passed++;
      if (want_c) begin
        exp_q.push_back('{cyc + 1, 1'b0, ref_mem[8'(8'h50 + n)]});
        n++;
      end else begin
        ref_mem[8'(8'h40 + k)] = 32'hB0000000 + 32'(k);
        k++;
      end
      cyc_next;
    end
    idle; cyc_next;
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      idle;
      if (i < 3) begin cpu_req = 1; cpu_addr = 8'(8'h40 + i); end
      else begin dbg_req = 1; dbg_addr = 8'h10; end
      @(negedge clk);
      total++; if (cpu_gnt !== (i < 3) || dbg_gnt !== (i == 3)) $display("FAIL b2b_gnt[%0d]: got cpu=%b dbg=%b want %b %b", i, cpu_gnt, dbg_gnt, i < 3, i == 3); else passed++;
      exp_q.push_back('{cyc + 1, i == 3, ref_mem[(i < 3) ? 8'(8'h40 + i) : 8'h10]});
      cyc_next;
    end
    idle; cyc_next;
  endtask
  task automatic test_reset_mid_read;
    cpu_req = 1; cpu_addr = 8'h04;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1) $display("FAIL rst_rd_gnt: got %b want 1", cpu_gnt); else passed++;
    exp_q.push_back('{cyc + 1, 1'b0, ref_mem[4]});
    cyc_next;
    reset = 1; dbg_req = 1; dbg_lock = 1;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0 || mem_en !== 1'b0) $display("FAIL rst_mid_gnts: got cpu=%b dbg=%b en=%b want 000", cpu_gnt, dbg_gnt, mem_en); else passed++;
    total++; if (cpu_stall !== 1'b1) $display("FAIL rst_mid_stall: got %b want 1", cpu_stall); else passed++;
    cyc_next;
    reset = 0; idle;
    @(negedge clk);
    total++; if (cpu_rvalid !== 1'b0) $display("FAIL rst_drop_rvalid: got %b want 0", cpu_rvalid); else passed++;
    cyc_next;
    dbg_req = 1; dbg_lock = 1; dbg_addr = 8'h10;
    @(negedge clk);
    total++; if (dbg_gnt !== 1'b1) $display("FAIL rst_lock_gnt: got %b want 1", dbg_gnt); else passed++;
    exp_q.push_back('{cyc + 1, 1'b1, ref_mem[8'h10]});
    cyc_next;
    reset = 1; cpu_req = 1;
    cyc_next;
    reset = 0; dbg_req = 0; cpu_req = 1; cpu_addr = 8'h42;
    @(negedge clk);
    total++; if (cpu_gnt !== 1'b1) $display("FAIL rst_owner_none: got cpu_gnt=%b want 1", cpu_gnt); else passed++;
    exp_q.push_back('{cyc + 1, 1'b0, ref_mem[8'h42]});
    cyc_next; idle; cyc_next;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    reset = 1; idle;
    fork
      begin
        test_reset;
        test_cpu_read;
        test_dbg_write_cpu_read;
`ifndef DMEM_ARB_RR_EN
        test_priority;
`else
        test_round_robin;
`endif
        test_starvation;
        test_back_to_back;
        test_reset_mid_read;
        cyc_next; cyc_next;
        total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size()); else passed++;
      end
      begin
        logic ec, ed;
        forever begin
          @(negedge clk);
          ec = exp_q.size() > 0 && exp_q[0].due == cyc && !exp_q[0].who;
          ed = exp_q.size() > 0 && exp_q[0].due == cyc && exp_q[0].who;
          if (cpu_rvalid === 1'b1 || ec) begin
            total++;
            if (cpu_rvalid !== ec || (ec && cpu_rdata !== exp_q[0].data))
              $display("FAIL cpu_resp cyc %0d: got %b/%h want %b/%h", cyc, cpu_rvalid, cpu_rdata, ec, ec ? exp_q[0].data : '0);
            else passed++;
          end
          if (dbg_rvalid === 1'b1 || ed) begin
            total++;
            if (dbg_rvalid !== ed || (ed && dbg_rdata !== exp_q[0].data))
              $display("FAIL dbg_resp cyc %0d: got %b/%h want %b/%h", cyc, dbg_rvalid, dbg_rdata, ed, ed ? exp_q[0].data : '0);
            else passed++;
          end
          if (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
        end
      end
    join_any
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
